comparator_seq_ctrl: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands using one 2-bit comparator slice per clock. It walks the operands MSB-slice first and stops early at the first slice that differs. It gives the 4-bit/N-bit compare a start/busy/done handshake, so wide compares cost one 2-bit slice of area instead of a full-width tree. It sits between a requesting datapath and the shared slice compare function.

---
 rtl/comparator_seq_ctrl.sv | 103 ++++++++++
 tb/tb_comparator_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/comparator_seq_ctrl.sv
// rtl/comparator_seq_ctrl.sv - sequential MSB-first unsigned comparator using one 2-bit slice per clock
module comparator_seq_ctrl #(
    parameter int WIDTH = 8,
    localparam int SLICES = WIDTH / 2,
    localparam int CW = $clog2(SLICES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             a_greater,
    output logic             a_equal,
    output logic             a_less,
    output logic [CW-1:0]    cycles_used
);

    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("comparator_seq_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [1:0]       sa;
    logic [1:0]       sb;

    // The single shared 2-bit slice, selected by the walking index.
    assign sa = a_q[{idx, 1'b0} +: 2];
    assign sb = b_q[{idx, 1'b0} +: 2];

    assign busy = (state == COMPARE) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            cnt         <= '0;
            a_greater   <= 1'b0;
            a_equal     <= 1'b0;
            a_less      <= 1'b0;
            cycles_used <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        idx   <= IW'(SLICES - 1);
                        cnt   <= '0;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    cnt <= cnt + CW'(1);
                    if (sa > sb) begin
                        a_greater   <= 1'b1;
                        a_equal     <= 1'b0;
                        a_less      <= 1'b0;
                        cycles_used <= cnt + CW'(1);
                        state       <= DONE;
                    end else if (sa < sb) begin
                        a_greater   <= 1'b0;
                        a_equal     <= 1'b0;
                        a_less      <= 1'b1;
                        cycles_used <= cnt + CW'(1);
                        state       <= DONE;
                    end else if (idx == '0) begin
                        a_greater   <= 1'b0;
                        a_equal     <= 1'b1;
                        a_less      <= 1'b0;
                        cycles_used <= CW'(SLICES);
                        state       <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// tb/tb_comparator_seq_ctrl.sv - self-checking bench for comparator_seq_ctrl (WIDTH=8 and WIDTH=2)
module tb_comparator_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s8, busy8, done8, g8, e8, l8;
    logic [7:0] a8, b8;
    logic [2:0] cu8;
    logic       s2, busy2, done2, g2, e2, l2;
    logic [1:0] a2, b2;
    logic [0:0] cu2;

    int checks = 0;
    int errors = 0;

    comparator_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .a_greater(g8), .a_equal(e8), .a_less(l8),
        .cycles_used(cu8)
    );

    comparator_seq_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .a_in(a2), .b_in(b2),
        .busy(busy2), .done(done2), .a_greater(g2), .a_equal(e2), .a_less(l2),
        .cycles_used(cu2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: slices examined = position of the highest differing bit, counted in 2-bit slices from the top.
    function automatic int model_k(input logic [7:0] a, input logic [7:0] b, input int slices);
        logic [7:0] d;
        int msb;
        d = a ^ b;
        if (d == 8'd0) return slices;
        msb = 0;
        for (int i = 0; i < 8; i++) if (d[i]) msb = i;
        return slices - msb / 2;
    endfunction

    task automatic set_in(input bit w2, input logic st, input logic [7:0] a, input logic [7:0] b);
        if (w2) begin
            s2 = st; a2 = a[1:0]; b2 = b[1:0];
        end else begin
            s8 = st; a8 = a; b8 = b;
        end
    endtask

    task automatic get_obs(input bit w2, output logic bz, output logic dn, output logic g,
                           output logic e, output logic l, output logic [2:0] cu);
        if (w2) begin
            bz = busy2; dn = done2; g = g2; e = e2; l = l2; cu = {2'b00, cu2};
        end else begin
            bz = busy8; dn = done8; g = g8; e = e8; l = l8; cu = cu8;
        end
    endtask

    task automatic check_idle_zero(input bit w2, input string tag);
        logic bz, dn, g, e, l;
        logic [2:0] cu;
        get_obs(w2, bz, dn, g, e, l, cu);
        check({tag, "_busy"}, bz, 0);
        check({tag, "_done"}, dn, 0);
        check({tag, "_flags"}, {g, e, l}, 3'b000);
        check({tag, "_cycles"}, cu, 0);
    endtask

    // One full compare: latency, busy length, single done pulse, flags, cycles_used, operand capture.
    task automatic run_cmp(input bit w2, input logic [7:0] a_raw, input logic [7:0] b_raw, input string tag);
        logic [7:0] a, b;
        logic bz, dn, g, e, l;
        logic [2:0] cu;
        int k, n, busy_n;
        a = w2 ? {6'd0, a_raw[1:0]} : a_raw;
        b = w2 ? {6'd0, b_raw[1:0]} : b_raw;
        k = model_k(a, b, w2 ? 1 : 4);
        n = 0;
        busy_n = 0;
        @(negedge clk);
        set_in(w2, 1'b1, a, b);
        @(posedge clk);
        #1 set_in(w2, 1'b0, 8'($urandom), 8'($urandom));
        for (int c = 1; c <= 12 && n == 0; c++) begin
            @(negedge clk);
            get_obs(w2, bz, dn, g, e, l, cu);
            if (bz) busy_n++;
            if (dn) n = c;
        end
        check({tag, "_latency"}, n, k + 1);
        check({tag, "_busylen"}, busy_n, k + 1);
        check({tag, "_flags"}, {g, e, l}, {a > b, a == b, a < b});
        check({tag, "_cycles"}, cu, k);
        @(negedge clk);
        get_obs(w2, bz, dn, g, e, l, cu);
        check({tag, "_done_drop"}, {bz, dn}, 2'b00);
        check({tag, "_hold"}, {g, e, l}, {a > b, a == b, a < b});
    endtask

    initial begin
        logic bz, dn, g, e, l;
        logic [2:0] cu;
        int n;
        rst_n = 1'b0;
        set_in(0, 1'b0, 8'd0, 8'd0);
        set_in(1, 1'b0, 8'd0, 8'd0);

        // Reset state, then a mid-idle reset pulse.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero(0, "reset8");
        check_idle_zero(1, "reset2");
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero(0, "idle_pulse");

        // Directed cases.
        run_cmp(0, 8'hC3, 8'h43, "msb_greater");
        run_cmp(0, 8'h5A, 8'h5A, "equal");
        run_cmp(0, 8'h12, 8'h13, "lsb_less");

        // Start held high during busy with changing operands; re-accepted in the IDLE cycle after done.
        @(negedge clk);
        set_in(0, 1'b1, 8'h80, 8'h7F);
        @(posedge clk);
        n = 0;
        for (int c = 1; c <= 12 && n == 0; c++) begin
            #1 set_in(0, 1'b1, 8'($urandom), 8'($urandom));
            @(negedge clk);
            if (done8) n = c;
        end
        check("held_latency", n, 2);
        check("held_flags", {g8, e8, l8}, 3'b100);
        check("held_cycles", cu8, 1);
        set_in(0, 1'b1, 8'h12, 8'h13);
        @(negedge clk);
        check("held_idle_busy", busy8, 0);
        check("held_idle_flags", {g8, e8, l8}, 3'b100);
        @(negedge clk);
        check("held_accept_busy", busy8, 1);
        check("held_accept_flags", {g8, e8, l8}, 3'b100);
        set_in(0, 1'b0, 8'h00, 8'hFF);
        n = 0;
        for (int c = 2; c <= 12 && n == 0; c++) begin
            @(negedge clk);
            if (done8) n = c;
        end
        check("held_second_latency", n, 5);
        check("held_second_flags", {g8, e8, l8}, 3'b001);
        check("held_second_cycles", cu8, 4);

        // Reset asserted mid-compare aborts without a done pulse.
        @(negedge clk);
        set_in(0, 1'b1, 8'h01, 8'h02);
        @(posedge clk);
        #1 set_in(0, 1'b0, 8'h01, 8'h02);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_idle_zero(0, "abort");
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done8) n++;
        end
        check("abort_no_done", n, 0);
        rst_n = 1'b1;
        run_cmp(0, 8'h01, 8'h01, "after_abort");

        // Randomized compares, biased so that shared upper slices are common.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ 8'($urandom_range(1, 3));
                2: rb = ra ^ 8'($urandom_range(1, 15));
                default: rb = 8'($urandom);
            endcase
            run_cmp(0, ra, rb, $sformatf("rand%0d", i));
        end

        // WIDTH=2 exhaustive sweep.
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                run_cmp(1, 8'(ia), 8'(ib), $sformatf("w2_%0d_%0d", ia, ib));
            end
        end

        get_obs(1, bz, dn, g, e, l, cu);
        check("w2_final_idle", {bz, dn}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
